// File: rtl/shifter_pkg.sv
// Shared constants for the shifter slice.
package shifter_pkg;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shifter_core.sv
// Combinational log2(WIDTH)-stage barrel shifter/rotator.
module shifter_core
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    b,
    input  logic             rot,
    input  logic             left,
    input  logic             sign,
    output logic [WIDTH-1:0] y
);

    logic             fill_bit;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] stage_cur;
    logic [WIDTH-1:0] stage_nxt;

    // Left operations run through the right-moving stages on bit-reversed data.
    always_comb begin
        fill_bit = ~rot & ~left & sign & a[WIDTH-1];
        a_in     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_in[i] = left ? a[WIDTH-1-i] : a[i];
        end
        stage_cur = a_in;
        stage_nxt = '0;
        for (int k = 0; k < SW; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i + (1 << k) < WIDTH) begin
                    stage_nxt[i] = stage_cur[i + (1 << k)];
                end else begin
                    stage_nxt[i] = rot ? stage_cur[i + (1 << k) - WIDTH] : fill_bit;
                end
            end
            if (b[k]) begin
                stage_cur = stage_nxt;
            end
        end
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = left ? stage_cur[WIDTH-1-i] : stage_cur[i];
        end
    end

endmodule

// File: rtl/shifter.sv
// Registered shifter: one-cycle latency, output holds while in_valid is low.
module shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    b,
    input  logic             rot,
    input  logic             left,
    input  logic             sign,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    shifter_core #(.WIDTH(WIDTH)) u_core (
        .a    (a),
        .b    (b),
        .rot  (rot),
        .left (left),
        .sign (sign),
        .y    (y)
    );

    always_comb begin
        out_d   = in_valid ? y : out_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter (WIDTH=8 and WIDTH=16 instances).
module tb_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  a = '0;
    logic [2:0]  b = '0;
    logic        rot = 1'b0, left = 1'b0, sign = 1'b0, in_valid = 1'b0;
    logic [7:0]  out;
    logic        out_valid;

    logic [15:0] a16 = '0;
    logic [3:0]  b16 = '0;
    logic        rot16 = 1'b0, left16 = 1'b0, sign16 = 1'b0, in_valid16 = 1'b0;
    logic [15:0] out16;
    logic        out_valid16;

    int n_cmp = 0;
    int n_err = 0;

    shifter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .rot(rot), .left(left),
        .sign(sign), .in_valid(in_valid), .out(out), .out_valid(out_valid)
    );

    shifter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .rot(rot16), .left(left16),
        .sign(sign16), .in_valid(in_valid16), .out(out16), .out_valid(out_valid16)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on a 32-bit container, masked to w bits.
    function automatic logic [31:0] ref_model(int w, logic [31:0] av, int bv,
                                              logic r, logic l, logic s);
        logic [31:0] mask;
        logic [31:0] res;
        mask = (32'd1 << w) - 32'd1;
        av   = av & mask;
        if (r && l)       res = (av << bv) | (av >> (w - bv));
        else if (r)       res = (av >> bv) | (av << (w - bv));
        else if (l)       res = av << bv;
        else if (s && av[w-1]) res = (av >> bv) | (mask & ~(mask >> bv));
        else              res = av >> bv;
        return res & mask;
    endfunction

    task automatic drive(input logic [7:0] av, input logic [2:0] bv,
                         input logic r, input logic l, input logic s, input logic v);
        a = av; b = bv; rot = r; left = l; sign = s; in_valid = v;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset8: out=%h valid=%b expected out=00 valid=0", out, out_valid);
        end
        n_cmp++;
        if (out16 !== 16'h0000 || out_valid16 !== 1'b0) begin
            n_err++;
            $display("FAIL reset16: out=%h valid=%b expected out=0000 valid=0", out16, out_valid16);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_vectors();
        logic [7:0] exp;
        for (int l = 1; l >= 0; l--) begin
            for (int i = 0; i < 8; i++) begin
                drive(8'b1000_0111, 3'(i), 1'b1, 1'(l), 1'($urandom_range(0, 1)), 1'b1);
                exp = 8'(ref_model(8, 32'h87, i, 1'b1, 1'(l), 1'b0));
                if (l == 1 && i == 1) exp = 8'b0000_1111;
                if (l == 0 && i == 1) exp = 8'b1100_0011;
                if (l == 1 && i == 7) exp = 8'b1100_0011;
                @(posedge clk); #1;
                n_cmp++;
                if (out !== exp || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL rotate l=%0d b=%0d: out=%b valid=%b expected %b valid=1",
                             l, i, out, out_valid, exp);
                end
            end
        end
    endtask

    task automatic test_shift_vectors();
        logic [7:0] va [4] = '{8'b1000_0111, 8'b1000_0111, 8'b1000_0111, 8'b0111_0000};
        logic       vl [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       vs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] ve [4] = '{8'b0011_1000, 8'b0001_0000, 8'b1111_0000, 8'b0000_1110};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], 3'd3, 1'b0, vl[i], vs[i], 1'b1);
            @(posedge clk); #1;
            n_cmp++;
            if (out !== ve[i]) begin
                n_err++;
                $display("FAIL shift_vec%0d: out=%b expected %b", i, out, ve[i]);
            end
        end
        // maximum amount and zero amount boundaries
        drive(8'b1000_0111, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (out !== 8'hFF) begin
            n_err++;
            $display("FAIL asr_max: out=%b expected 11111111", out);
        end
        drive(8'b1000_0111, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (out !== 8'h01) begin
            n_err++;
            $display("FAIL lsr_max: out=%b expected 00000001", out);
        end
        drive(8'b1000_0111, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (out !== 8'h87) begin
            n_err++;
            $display("FAIL b_zero: out=%b expected 10000111", out);
        end
    endtask

    task automatic test_random();
        logic [7:0] av; logic [2:0] bv; logic r, l, s; logic [7:0] exp;
        for (int i = 0; i < 60; i++) begin
            av = 8'($urandom); bv = 3'($urandom); r = 1'($urandom);
            l = 1'($urandom); s = 1'($urandom);
            drive(av, bv, r, l, s, 1'b1);
            exp = 8'(ref_model(8, 32'(av), int'(bv), r, l, s));
            @(posedge clk); #1;
            n_cmp++;
            if (out !== exp) begin
                n_err++;
                $display("FAIL random a=%h b=%0d rot=%b left=%b sign=%b: out=%h expected %h",
                         av, bv, r, l, s, out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av; logic [2:0] bv; logic r, l, s, v; logic [7:0] held;
        drive(8'h5A, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        held = 8'h5A;
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            av = 8'($urandom); bv = 3'($urandom); r = 1'($urandom);
            l = 1'($urandom); s = 1'($urandom); v = ($urandom_range(0, 3) != 0);
            drive(av, bv, r, l, s, v);
            if (v) held = 8'(ref_model(8, 32'(av), int'(bv), r, l, s));
            @(posedge clk); #1;
            n_cmp++;
            if (out !== held || out_valid !== v) begin
                n_err++;
                $display("FAIL b2b cyc%0d: out=%h valid=%b expected %h valid=%b",
                         i, out, out_valid, held, v);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(8'hC3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out !== 8'h00 || out_valid !== 1'b0 || out16 !== 16'h0 || out_valid16 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: out=%h valid=%b out16=%h valid16=%b expected all 0",
                     out, out_valid, out16, out_valid16);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: out=%h valid=%b expected 00 0", out, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'b1000_0111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (out !== 8'b1100_0011 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: out=%b valid=%b expected 11000011 1", out, out_valid);
        end
        drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_width16();
        logic [15:0] av; logic [3:0] bv; logic r, l, s; logic [15:0] exp;
        a16 = 16'h8001; b16 = 4'd15; rot16 = 1'b1; left16 = 1'b1; sign16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out16 !== 16'hC000 || out_valid16 !== 1'b1) begin
            n_err++;
            $display("FAIL w16_rol: out=%h valid=%b expected c000 1", out16, out_valid16);
        end
        rot16 = 1'b0; left16 = 1'b0; sign16 = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out16 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL w16_asr: out=%h expected ffff", out16);
        end
        for (int i = 0; i < 30; i++) begin
            av = 16'($urandom); bv = 4'($urandom); r = 1'($urandom);
            l = 1'($urandom); s = 1'($urandom);
            a16 = av; b16 = bv; rot16 = r; left16 = l; sign16 = s;
            exp = 16'(ref_model(16, 32'(av), int'(bv), r, l, s));
            @(posedge clk); #1;
            n_cmp++;
            if (out16 !== exp) begin
                n_err++;
                $display("FAIL w16_random a=%h b=%0d rot=%b left=%b sign=%b: out=%h expected %h",
                         av, bv, r, l, s, out16, exp);
            end
        end
        in_valid16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate_vectors();
        test_shift_vectors();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
